// File: rtl/layered_color_mapper.sv
// Two-stage pixel compositor: frog box over object rows over a background that a
// per-frame collision flash can tint. Object positions are latched once per frame.
module layered_color_mapper #(
    parameter int NUM_ROWS     = 4,
    parameter int OBJS_PER_ROW = 4,
    parameter int COORD_W      = 11,
    parameter int OBJ_W        = 80,
    parameter int OBJ_H        = 40,
    parameter int FLASH_FRAMES = 30
) (
    input  logic                                     Clk,
    input  logic                                     Reset,
    input  logic                                     frame_start,
    input  logic                                     pix_valid,
    input  logic [COORD_W-1:0]                       DrawX,
    input  logic [COORD_W-1:0]                       DrawY,
    input  logic [NUM_ROWS*OBJS_PER_ROW*COORD_W-1:0] obj_x,
    input  logic [NUM_ROWS*OBJS_PER_ROW*COORD_W-1:0] obj_y,
    input  logic [NUM_ROWS*3-1:0]                    row_count,
    input  logic [NUM_ROWS*24-1:0]                   row_rgb,
    input  logic [COORD_W-1:0]                       FrogX,
    input  logic [COORD_W-1:0]                       FrogY,
    input  logic [COORD_W-1:0]                       Frog_Width,
    input  logic [COORD_W-1:0]                       Frog_Height,
    input  logic [23:0]                              frog_rgb,
    input  logic [23:0]                              bg_rgb,
    input  logic [23:0]                              flash_rgb,
    input  logic [NUM_ROWS-1:0]                      collision,
    output logic [7:0]                               Red,
    output logic [7:0]                               Green,
    output logic [7:0]                               Blue,
    output logic                                     out_valid,
    output logic [$clog2(NUM_ROWS):0]                hit_row,
    output logic                                     flash_active
);

    localparam int NUM_SLOTS = NUM_ROWS * OBJS_PER_ROW;
    localparam int CW1       = COORD_W + 1;
    localparam int HR_W      = $clog2(NUM_ROWS) + 1;
    localparam logic [HR_W-1:0]         ROW_NONE   = {HR_W{1'b1}};
    localparam logic signed [COORD_W:0] OBJ_W_M1   = CW1'(OBJ_W - 1);
    localparam logic [COORD_W:0]        OBJ_H_M1   = CW1'(OBJ_H - 1);
    localparam logic [7:0]              FLASH_LOAD = 8'(FLASH_FRAMES);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLASH    = 2'd1,
        COOLDOWN = 2'd2
    } flash_state_t;

    logic [NUM_SLOTS*COORD_W-1:0] shadow_x_r;
    logic [NUM_SLOTS*COORD_W-1:0] shadow_y_r;
    logic [NUM_ROWS*3-1:0]        shadow_cnt_r;

    logic [NUM_ROWS-1:0] row_hit_s;
    logic                frog_hit_s;
    logic                v1_r;
    logic                frog_hit1_r;
    logic [NUM_ROWS-1:0] row_hit1_r;

    logic [23:0]     pix_rgb_s;
    logic [HR_W-1:0] pix_row_s;

    flash_state_t state_r, state_s;
    logic [7:0]   cnt_r, cnt_s;
    logic [1:0]   fcnt_r, fcnt_s;
    logic         phase_r, phase_s;
    logic         flash_active_r;

    // x is two's complement so objects can slide in past the left edge; y is unsigned.
    function automatic logic obj_hit(input logic [COORD_W-1:0] ox, input logic [COORD_W-1:0] oy,
                                     input logic [COORD_W-1:0] dx, input logic [COORD_W-1:0] dy);
        logic signed [COORD_W:0] xs, xe, dxs;
        logic [COORD_W:0]        ys, ye, dyu;
        xs  = {ox[COORD_W-1], ox};
        xe  = xs + OBJ_W_M1;
        dxs = {1'b0, dx};
        ys  = {1'b0, oy};
        ye  = ys + OBJ_H_M1;
        dyu = {1'b0, dy};
        return (xs <= dxs) && (dxs <= xe) && (ys <= dyu) && (dyu <= ye);
    endfunction

    function automatic logic frog_hit(input logic [COORD_W-1:0] dx, input logic [COORD_W-1:0] dy);
        logic [COORD_W:0] x0, y0, px, py;
        x0 = {1'b0, FrogX};
        y0 = {1'b0, FrogY};
        px = {1'b0, dx};
        py = {1'b0, dy};
        return (x0 <= px) && (px < x0 + {1'b0, Frog_Width}) &&
               (y0 <= py) && (py < y0 + {1'b0, Frog_Height});
    endfunction

    // k never reaches OBJS_PER_ROW, so k < count already equals k < min(count, OBJS_PER_ROW).
    function automatic logic slot_active(input logic [2:0] cnt, input int k);
        return int'(cnt) > k;
    endfunction

    function automatic logic [HR_W-1:0] first_row(input logic [NUM_ROWS-1:0] hits);
        logic [HR_W-1:0] idx;
        idx = ROW_NONE;
        for (int r = NUM_ROWS - 1; r >= 0; r--) begin
            idx = hits[r] ? HR_W'(r) : idx;
        end
        return idx;
    endfunction

    function automatic logic [23:0] row_color(input logic [NUM_ROWS-1:0] hits);
        logic [23:0] c;
        c = 24'h000000;
        for (int r = NUM_ROWS - 1; r >= 0; r--) begin
            c = hits[r] ? row_rgb[r*24 +: 24] : c;
        end
        return c;
    endfunction

    // Frame-latched copy of object positions and row populations
    always_ff @(posedge Clk) begin
        if (Reset) begin
            shadow_x_r   <= '0;
            shadow_y_r   <= '0;
            shadow_cnt_r <= '0;
        end else if (frame_start) begin
            shadow_x_r   <= obj_x;
            shadow_y_r   <= obj_y;
            shadow_cnt_r <= row_count;
        end
    end

    // Per-row hit flags against the shadowed objects
    always_comb begin
        row_hit_s = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            for (int k = 0; k < OBJS_PER_ROW; k++) begin
                row_hit_s[r] = row_hit_s[r] |
                    (slot_active(shadow_cnt_r[r*3 +: 3], k) &
                     obj_hit(shadow_x_r[(r*OBJS_PER_ROW+k)*COORD_W +: COORD_W],
                             shadow_y_r[(r*OBJS_PER_ROW+k)*COORD_W +: COORD_W],
                             DrawX, DrawY));
            end
        end
    end

    assign frog_hit_s = frog_hit(DrawX, DrawY);

    // Stage 1: register hit results alongside the valid bit
    always_ff @(posedge Clk) begin
        if (Reset) begin
            v1_r        <= 1'b0;
            frog_hit1_r <= 1'b0;
            row_hit1_r  <= '0;
        end else begin
            v1_r        <= pix_valid;
            frog_hit1_r <= pix_valid & frog_hit_s;
            row_hit1_r  <= pix_valid ? row_hit_s : '0;
        end
    end

    // Layer priority: frog, lowest row, flash tint, background; bubbles go black
    always_comb begin
        pix_rgb_s = 24'h000000;
        pix_row_s = ROW_NONE;
        if (!v1_r) begin
            pix_rgb_s = 24'h000000;
        end else if (frog_hit1_r) begin
            pix_rgb_s = frog_rgb;
        end else if (|row_hit1_r) begin
            pix_rgb_s = row_color(row_hit1_r);
            pix_row_s = first_row(row_hit1_r);
        end else if (flash_active_r && phase_r) begin
            pix_rgb_s = flash_rgb;
        end else begin
            pix_rgb_s = bg_rgb;
        end
    end

    // Stage 2: registered pixel output
    always_ff @(posedge Clk) begin
        if (Reset) begin
            Red       <= 8'd0;
            Green     <= 8'd0;
            Blue      <= 8'd0;
            out_valid <= 1'b0;
            hit_row   <= ROW_NONE;
        end else begin
            {Red, Green, Blue} <= pix_rgb_s;
            out_valid          <= v1_r;
            hit_row            <= pix_row_s;
        end
    end

    // Flash sequencing; collisions are ignored outside IDLE so a held level cannot reload
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        fcnt_s  = fcnt_r;
        phase_s = phase_r;
        case (state_r)
            IDLE: begin
                if (|collision) begin
                    state_s = FLASH;
                    cnt_s   = FLASH_LOAD;
                    fcnt_s  = 2'd0;
                    phase_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            FLASH: begin
                if (frame_start) begin
                    cnt_s   = cnt_r - 8'd1;
                    fcnt_s  = fcnt_r + 2'd1;
                    phase_s = (fcnt_r == 2'd3) ? ~phase_r : phase_r;
                    state_s = (cnt_r == 8'd1) ? COOLDOWN : FLASH;
                end else begin
                    state_s = FLASH;
                end
            end
            COOLDOWN: begin
                if (frame_start) begin
                    state_s = IDLE;
                end else begin
                    state_s = COOLDOWN;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Flash state register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r        <= IDLE;
            cnt_r          <= 8'd0;
            fcnt_r         <= 2'd0;
            phase_r        <= 1'b0;
            flash_active_r <= 1'b0;
        end else begin
            state_r        <= state_s;
            cnt_r          <= cnt_s;
            fcnt_r         <= fcnt_s;
            phase_r        <= phase_s;
            flash_active_r <= (state_s == FLASH);
        end
    end

    assign flash_active = flash_active_r;

endmodule

// File: tb/tb_layered_color_mapper.sv
// Directed and randomised bench for layered_color_mapper, compared every cycle
// against an integer-geometry reference of the compositor and flash sequence.
module tb_layered_color_mapper;

    localparam int NR = 4;
    localparam int OPR = 4;
    localparam int CW = 11;
    localparam int OW = 80;
    localparam int OH = 40;
    localparam int FF = 3;
    localparam int NS = NR * OPR;

    logic            Clk = 1'b0;
    logic            Reset = 1'b1;
    logic            frame_start = 1'b0;
    logic            pix_valid = 1'b0;
    logic [CW-1:0]   DrawX = 11'd0, DrawY = 11'd0;
    logic [NS*CW-1:0] obj_x = '0, obj_y = '0;
    logic [NR*3-1:0] row_count = '0;
    logic [NR*24-1:0] row_rgb = '0;
    logic [CW-1:0]   FrogX = 11'd0, FrogY = 11'd0, Frog_Width = 11'd0, Frog_Height = 11'd0;
    logic [23:0]     frog_rgb = 24'd0, bg_rgb = 24'd0, flash_rgb = 24'd0;
    logic [NR-1:0]   collision = 4'd0;
    logic [7:0]      Red, Green, Blue;
    logic            out_valid;
    logic [2:0]      hit_row;
    logic            flash_active;

    layered_color_mapper #(
        .NUM_ROWS(NR), .OBJS_PER_ROW(OPR), .COORD_W(CW),
        .OBJ_W(OW), .OBJ_H(OH), .FLASH_FRAMES(FF)
    ) dut (
        .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .pix_valid(pix_valid),
        .DrawX(DrawX), .DrawY(DrawY), .obj_x(obj_x), .obj_y(obj_y),
        .row_count(row_count), .row_rgb(row_rgb),
        .FrogX(FrogX), .FrogY(FrogY), .Frog_Width(Frog_Width), .Frog_Height(Frog_Height),
        .frog_rgb(frog_rgb), .bg_rgb(bg_rgb), .flash_rgb(flash_rgb), .collision(collision),
        .Red(Red), .Green(Green), .Blue(Blue), .out_valid(out_valid),
        .hit_row(hit_row), .flash_active(flash_active)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        bit          v;
        logic [23:0] rgb;
        logic [2:0]  row;
    } pix_t;

    int bx[NS], by[NS], bc[NR];
    int sx[NS], sy[NS], sc[NR];
    logic [23:0] rrgb[NR];
    int m_state, m_left, m_seen;
    bit m_phase;
    pix_t s1, s2;
    int n_cmp = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic pix_t bub();
        pix_t p;
        p.v = 1'b0; p.rgb = 24'h000000; p.row = 3'b111;
        return p;
    endfunction

    // Expected pixel from geometry: frog, then lowest row, then tint, then background
    function automatic pix_t ref_pix();
        pix_t p;
        int dx, dy, xs, cnt, i;
        dx = int'(DrawX); dy = int'(DrawY);
        p.v = 1'b1; p.row = 3'b111;
        if (dx >= int'(FrogX) && dx < int'(FrogX) + int'(Frog_Width) &&
            dy >= int'(FrogY) && dy < int'(FrogY) + int'(Frog_Height)) begin
            p.rgb = frog_rgb;
            return p;
        end
        for (int r = 0; r < NR; r++) begin
            cnt = (sc[r] > OPR) ? OPR : sc[r];
            for (int k = 0; k < cnt; k++) begin
                i = r * OPR + k;
                xs = (sx[i] >= 1024) ? sx[i] - 2048 : sx[i];
                if (dx >= xs && dx <= xs + OW - 1 && dy >= sy[i] && dy <= sy[i] + OH - 1) begin
                    p.rgb = rrgb[r];
                    p.row = 3'(r);
                    return p;
                end
            end
        end
        p.rgb = (m_state == 1 && m_phase) ? flash_rgb : bg_rgb;
        return p;
    endfunction

    task automatic drive_objs();
        for (int i = 0; i < NS; i++) begin
            obj_x[i*CW +: CW] = CW'(bx[i]);
            obj_y[i*CW +: CW] = CW'(by[i]);
        end
        for (int r = 0; r < NR; r++) row_count[r*3 +: 3] = 3'(bc[r]);
    endtask

    // Advance the model for the inputs now applied, clock once, compare outputs
    task automatic tick();
        pix_t np;
        if (Reset) begin
            m_state = 0; m_left = 0; m_seen = 0; m_phase = 1'b0;
            for (int i = 0; i < NS; i++) begin sx[i] = 0; sy[i] = 0; end
            for (int r = 0; r < NR; r++) sc[r] = 0;
            s1 = bub(); s2 = bub();
        end else begin
            if (m_state == 0) begin
                if (collision != 4'd0) begin
                    m_state = 1; m_left = FF; m_seen = 0; m_phase = 1'b1;
                end
            end else if (m_state == 1) begin
                if (frame_start) begin
                    if (m_seen % 4 == 3) m_phase = !m_phase;
                    m_seen++;
                    m_left--;
                    if (m_left == 0) m_state = 2;
                end
            end else begin
                if (frame_start) m_state = 0;
            end
            np = pix_valid ? ref_pix() : bub();
            if (frame_start) begin
                for (int i = 0; i < NS; i++) begin sx[i] = bx[i]; sy[i] = by[i]; end
                for (int r = 0; r < NR; r++) sc[r] = bc[r];
            end
            s2 = s1; s1 = np;
        end
        @(posedge Clk);
        #1;
        chk("out_valid", 32'(out_valid), 32'(s2.v));
        chk("rgb", 32'({Red, Green, Blue}), 32'(s2.rgb));
        chk("hit_row", 32'(hit_row), 32'(s2.row));
        chk("flash_active", 32'(flash_active), 32'(m_state == 1));
    endtask

    task automatic frame_pulse();
        frame_start = 1'b1; tick(); frame_start = 1'b0;
    endtask

    task automatic pix(input int x, input int y);
        pix_valid = 1'b1; DrawX = CW'(x); DrawY = CW'(y); tick();
    endtask

    task automatic flush();
        pix_valid = 1'b0; tick(); tick();
    endtask

    task automatic bg_frames(input int n);
        for (int f = 0; f < n; f++) begin
            pix_valid = 1'b1; DrawX = 11'd1500; DrawY = 11'd1500;
            frame_pulse();
            for (int c = 0; c < 5; c++) pix(1500 + c, 1500);
        end
    endtask

    task automatic rand_world();
        for (int i = 0; i < NS; i++) begin
            bx[i] = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 260)) : int'($urandom_range(1940, 2047));
            by[i] = int'($urandom_range(0, 180));
        end
        for (int r = 0; r < NR; r++) bc[r] = int'($urandom_range(0, 7));
        drive_objs();
        FrogX = 11'($urandom_range(0, 280)); FrogY = 11'($urandom_range(0, 190));
        Frog_Width = 11'($urandom_range(0, 40)); Frog_Height = 11'($urandom_range(0, 40));
    endtask

    initial begin
        for (int r = 0; r < NR; r++) begin
            rrgb[r] = {8'(r + 1), 16'($urandom)};
            row_rgb[r*24 +: 24] = rrgb[r];
        end
        frog_rgb  = {8'hF0, 16'($urandom)};
        bg_rgb    = {8'h10, 16'($urandom)};
        flash_rgb = {8'h20, 16'($urandom)};
        for (int i = 0; i < NS; i++) begin bx[i] = 1000; by[i] = 1000; end
        for (int r = 0; r < NR; r++) bc[r] = 0;
        drive_objs();

        Reset = 1'b1;
        repeat (3) tick();
        Reset = 1'b0;

        // Single object sweep across both horizontal edges
        bx[0] = 100; by[0] = 300; bc[0] = 1; drive_objs();
        frame_pulse();
        for (int x = 99; x <= 181; x++) pix(x, 310);
        flush();

        // Left-edge sliver, then an object entirely off-screen
        bc[0] = 0; bx[OPR] = 2040; by[OPR] = 300; bc[1] = 1; drive_objs();
        frame_pulse();
        for (int x = 0; x <= 75; x++) pix(x, 310);
        bx[OPR] = 1960; drive_objs();
        frame_pulse();
        for (int x = 0; x <= 20; x++) pix(x, 310);
        flush();

        // Overlaps: frog over rows, row 0 (count 7, slot 3) over rows 2 and 3
        bc[1] = 0;
        bx[3] = 400; by[3] = 500; bc[0] = 7;
        bx[2*OPR] = 400; by[2*OPR] = 500; bc[2] = 1;
        bx[3*OPR] = 400; by[3*OPR] = 500; bc[3] = 1;
        drive_objs();
        FrogX = 11'd410; FrogY = 11'd510; Frog_Width = 11'd20; Frog_Height = 11'd20;
        frame_pulse();
        pix(415, 515); pix(405, 505); pix(450, 520); pix(429, 529); pix(430, 529);
        Frog_Width = 11'd0;

        // Mid-frame move is invisible until the next frame latch
        bx[3] = 700; drive_objs();
        pix(405, 505); pix(705, 505);
        frame_pulse();
        pix(405, 505); pix(705, 505);
        flush();

        // Flash: single pulse, then a held collision through cooldown
        pix_valid = 1'b1; DrawX = 11'd1500; DrawY = 11'd1500;
        collision = 4'b0010; tick(); collision = 4'd0;
        bg_frames(5);
        collision = 4'b0010;
        bg_frames(5);
        collision = 4'd0;
        bg_frames(4);

        // Reset while flashing with pixels streaming
        collision = 4'b0100; pix(405, 505); collision = 4'd0;
        for (int c = 0; c < 8; c++) pix(390 + c * 3, 505);
        Reset = 1'b1; pix(405, 505);
        Reset = 1'b0;
        for (int c = 0; c < 6; c++) pix(700 + c, 505);
        flush();

        // Randomised traffic
        rand_world();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 49) == 0) rand_world();
            Reset       = ($urandom_range(0, 999) == 0);
            frame_start = ($urandom_range(0, 24) == 0);
            collision   = ($urandom_range(0, 39) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            pix_valid   = ($urandom_range(0, 3) != 0);
            DrawX       = 11'($urandom_range(0, 300));
            DrawY       = 11'($urandom_range(0, 200));
            tick();
        end
        Reset = 1'b0; frame_start = 1'b0; collision = 4'd0;
        flush();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
